// File: rtl/divisor_com_sinal.sv
// Sequential radix-2 restoring divider: 8-bit dividend / 4-bit divisor with per-operand signedness.
// Define DIVISOR_SATURA_EN to saturate the quotient on overflow instead of wrapping it.
module divisor_com_sinal (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       entrada_valid,
    output logic       entrada_ready,
    input  logic [7:0] entrada_dividendo,
    input  logic [3:0] entrada_divisor,
    input  logic [1:0] codigo,
    output logic       saida_valid,
    input  logic       saida_ready,
    output logic [7:0] quociente,
    output logic [7:0] resto,
    output logic       overflow,
    output logic       erro_div_zero
);

    typedef enum logic [1:0] {OCIOSO, CALCULA, AJUSTA, PRONTO} estado_t;

    estado_t    estado, prox_estado;
    logic       aceita, retira;
    logic [2:0] iter;

    logic       sinal_in_a, sinal_in_b;
    logic [7:0] mag_in_a;
    logic [3:0] mag_in_b;

    logic [7:0] q_p0;
    logic [3:0] rem_p0;
    logic [3:0] mag_b_p0;
    logic       sinal_a_p0, sinal_b_p0, sem_sinal_p0;

    logic [4:0] deslocado;
    logic       cabe;
    logic [3:0] novo_rem;

    function automatic logic calc_overflow(input logic [7:0] qm, input logic neg, input logic sem_sinal);
        if (sem_sinal)
            return 1'b0;
        return neg ? (qm > 8'd128) : (qm > 8'd127);
    endfunction

    function automatic logic [7:0] ajusta_quociente(input logic [7:0] qm, input logic neg, input logic ovf);
        logic [7:0] wrap;
        wrap = neg ? (~qm + 8'd1) : qm;
`ifdef DIVISOR_SATURA_EN
        if (ovf)
            return neg ? 8'h80 : 8'h7F;
`else
        if (ovf)
            return wrap;
`endif
        return wrap;
    endfunction

    function automatic logic [7:0] ajusta_resto(input logic [3:0] rm, input logic neg);
        return neg ? (~{4'b0000, rm} + 8'd1) : {4'b0000, rm};
    endfunction

    assign aceita = entrada_valid & entrada_ready;
    assign retira = saida_valid & saida_ready;

    // Operand conversion to sign + magnitude; |-128| still fits 8 bits, |-8| fits 4.
    always_comb begin
        sinal_in_a = ((codigo == 2'd0) || (codigo == 2'd2)) && entrada_dividendo[7];
        sinal_in_b = ((codigo == 2'd0) || (codigo == 2'd3)) && entrada_divisor[3];
        mag_in_a   = sinal_in_a ? (~entrada_dividendo + 8'd1) : entrada_dividendo;
        mag_in_b   = sinal_in_b ? (~entrada_divisor + 4'd1) : entrada_divisor;
    end

    always_comb begin
        deslocado = {rem_p0, q_p0[7]};
        cabe      = deslocado >= {1'b0, mag_b_p0};
        novo_rem  = cabe ? 4'(deslocado - {1'b0, mag_b_p0}) : deslocado[3:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado      <= OCIOSO;
            saida_valid <= 1'b0;
            iter        <= 3'd0;
        end else begin
            estado <= prox_estado;
            if (retira)
                saida_valid <= 1'b0;
            else if (estado == PRONTO)
                saida_valid <= 1'b1;
            if (estado == CALCULA)
                iter <= iter + 3'd1;
            else
                iter <= 3'd0;
        end
    end

    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO:  if (aceita) prox_estado = (entrada_divisor == 4'd0) ? PRONTO : CALCULA;
            CALCULA: if (iter == 3'd7) prox_estado = AJUSTA;
            AJUSTA:  prox_estado = PRONTO;
            PRONTO:  if (retira) prox_estado = OCIOSO;
            default: prox_estado = OCIOSO;
        endcase
    end

    always_comb begin
        entrada_ready = (estado == OCIOSO);
    end

    // Stage p0: operand capture on accept, then one quotient bit per CALCULA cycle.
    always_ff @(posedge clk) begin
        if (aceita) begin
            q_p0         <= mag_in_a;
            rem_p0       <= 4'd0;
            mag_b_p0     <= mag_in_b;
            sinal_a_p0   <= sinal_in_a;
            sinal_b_p0   <= sinal_in_b;
            sem_sinal_p0 <= (codigo == 2'd1);
        end else if (estado == CALCULA) begin
            q_p0   <= {q_p0[6:0], cabe};
            rem_p0 <= novo_rem;
        end
    end

    // Result registers: loaded in AJUSTA, or directly on accept for a zero divisor.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quociente     <= 8'd0;
            resto         <= 8'd0;
            overflow      <= 1'b0;
            erro_div_zero <= 1'b0;
        end else if (aceita && (entrada_divisor == 4'd0)) begin
            quociente     <= 8'hFF;
            resto         <= entrada_dividendo;
            overflow      <= 1'b0;
            erro_div_zero <= 1'b1;
        end else if (estado == AJUSTA) begin
            quociente     <= ajusta_quociente(q_p0, sinal_a_p0 ^ sinal_b_p0,
                                 calc_overflow(q_p0, sinal_a_p0 ^ sinal_b_p0, sem_sinal_p0));
            resto         <= ajusta_resto(rem_p0, sinal_a_p0);
            overflow      <= calc_overflow(q_p0, sinal_a_p0 ^ sinal_b_p0, sem_sinal_p0);
            erro_div_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_divisor_com_sinal.sv
// Directed bench for divisor_com_sinal: latency, signed/unsigned results, overflow, divide-by-zero,
// backpressure and mid-operation reset.
module tb_divisor_com_sinal;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       entrada_valid;
    logic       entrada_ready;
    logic [7:0] entrada_dividendo;
    logic [3:0] entrada_divisor;
    logic [1:0] codigo;
    logic       saida_valid;
    logic       saida_ready;
    logic [7:0] quociente;
    logic [7:0] resto;
    logic       overflow;
    logic       erro_div_zero;

    int vectors = 0;
    int miscompares = 0;
    int lat;

    always #5 clk = ~clk;

    divisor_com_sinal dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .entrada_valid     (entrada_valid),
        .entrada_ready     (entrada_ready),
        .entrada_dividendo (entrada_dividendo),
        .entrada_divisor   (entrada_divisor),
        .codigo            (codigo),
        .saida_valid       (saida_valid),
        .saida_ready       (saida_ready),
        .quociente         (quociente),
        .resto             (resto),
        .overflow          (overflow),
        .erro_div_zero     (erro_div_zero)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [1:0] c, input logic [7:0] a, input logic [3:0] b);
        int guard = 0;
        while (!entrada_ready && guard < 30) begin
            tick();
            guard++;
        end
        codigo            = c;
        entrada_dividendo = a;
        entrada_divisor   = b;
        entrada_valid     = 1'b1;
        tick();
        entrada_valid     = 1'b0;
        entrada_dividendo = 8'h00;
        entrada_divisor   = 4'h0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!saida_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic retire();
        saida_ready = 1'b1;
        tick();
        saida_ready = 1'b0;
        chk("retire_valid", {7'd0, saida_valid}, 8'd0);
        chk("retire_ready", {7'd0, entrada_ready}, 8'd1);
    endtask

    task automatic run_op(input string tag, input logic [1:0] c, input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic eo);
        start(c, a, b);
        wait_valid(lat);
        chk({tag, "_lat"}, 8'(lat), 8'd10);
        chk({tag, "_q"}, quociente, eq);
        chk({tag, "_r"}, resto, er);
        chk({tag, "_ovf"}, {7'd0, overflow}, {7'd0, eo});
        chk({tag, "_dz"}, {7'd0, erro_div_zero}, 8'd0);
        retire();
    endtask

    initial begin
        logic [7:0] q_ovf0, q_ovf3, q_hold, r_hold;
`ifdef DIVISOR_SATURA_EN
        q_ovf0 = 8'h7F;
        q_ovf3 = 8'h80;
`else
        q_ovf0 = 8'h80;
        q_ovf3 = 8'h01;
`endif
        rst_n = 1'b0;
        entrada_valid = 1'b0;
        entrada_dividendo = 8'h00;
        entrada_divisor = 4'h0;
        codigo = 2'd0;
        saida_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", {7'd0, saida_valid}, 8'd0);
        chk("rst_ready", {7'd0, entrada_ready}, 8'd1);
        chk("rst_q", quociente, 8'h00);
        chk("rst_r", resto, 8'h00);
        chk("rst_ovf", {7'd0, overflow}, 8'd0);
        chk("rst_dz", {7'd0, erro_div_zero}, 8'd0);
        rst_n = 1'b1;
        tick();

        run_op("u200_7", 2'd1, 8'd200, 4'd7, 8'h1C, 8'h04, 1'b0);
        run_op("s_m100_3", 2'd0, 8'h9C, 4'h3, 8'hDF, 8'hFF, 1'b0);
        run_op("su_m100_15", 2'd2, 8'h9C, 4'hF, 8'hFA, 8'hF6, 1'b0);
        run_op("s_m128_m1", 2'd0, 8'h80, 4'hF, q_ovf0, 8'h00, 1'b1);
        run_op("us_255_m1", 2'd3, 8'hFF, 4'hF, q_ovf3, 8'h00, 1'b1);
        run_op("s_m128_1", 2'd0, 8'h80, 4'h1, 8'h80, 8'h00, 1'b0);
        run_op("s_127_m8", 2'd0, 8'h7F, 4'h8, 8'hF1, 8'h07, 1'b0);
        run_op("u255_1", 2'd1, 8'hFF, 4'h1, 8'hFF, 8'h00, 1'b0);

        for (int c = 0; c < 4; c++) begin
            start(2'(c), 8'h5A, 4'h0);
            wait_valid(lat);
            chk("dz_lat", 8'(lat), 8'd1);
            chk("dz_flag", {7'd0, erro_div_zero}, 8'd1);
            chk("dz_q", quociente, 8'hFF);
            chk("dz_r", resto, 8'h5A);
            chk("dz_ovf", {7'd0, overflow}, 8'd0);
            retire();
        end

        start(2'd1, 8'd100, 4'd7);
        wait_valid(lat);
        chk("bp_lat", 8'(lat), 8'd10);
        q_hold = quociente;
        r_hold = resto;
        chk("bp_q0", q_hold, 8'd14);
        chk("bp_r0", r_hold, 8'd2);
        codigo = 2'd1;
        entrada_dividendo = 8'd50;
        entrada_divisor = 4'd5;
        entrada_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("bp_valid", {7'd0, saida_valid}, 8'd1);
            chk("bp_ready", {7'd0, entrada_ready}, 8'd0);
            chk("bp_q", quociente, q_hold);
            chk("bp_r", resto, r_hold);
        end
        entrada_valid = 1'b0;
        retire();
        tick();
        chk("bp_idle_valid", {7'd0, saida_valid}, 8'd0);

        start(2'd0, 8'h9C, 4'h3);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_valid", {7'd0, saida_valid}, 8'd0);
        chk("mr_ready", {7'd0, entrada_ready}, 8'd1);
        chk("mr_q", quociente, 8'h00);
        chk("mr_r", resto, 8'h00);
        chk("mr_ovf", {7'd0, overflow}, 8'd0);
        chk("mr_dz", {7'd0, erro_div_zero}, 8'd0);
        run_op("u100_10", 2'd1, 8'd100, 4'd10, 8'h0A, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
